regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_fsm.sv | 60 ++++++
 rtl/regfile_mp.sv | 74 +++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
// The clear FSM state type is used by both the top and the clear engine.
package regfile_pkg;

  typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t;

  localparam int RF_DATA_W  = 8;
  localparam int RF_ADDR_W  = 4;
  localparam int RF_NREGS   = 16;
  localparam int RF_NREAD   = 2;
  localparam bit RF_ZERO_REG = 1'b1;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks a pointer over every register, one per cycle,
// and flags writes that arrive while it is not idle.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int PTR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  input  logic             we,
  output rf_state_t        state,
  output logic [PTR_W-1:0] ptr,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_drop
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREGS - 1);

  rf_state_t        state_nxt;
  logic [PTR_W-1:0] ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_IDLE;
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      wr_drop <= we && (state != RF_IDLE);
    end
  end

  // The pointer holds at the last index in CLEAR so it never wraps.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          ptr_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        if (ptr == PTR_LAST) state_nxt = RF_DONE;
        else                 ptr_nxt   = ptr + 1'b1;
      end
      RF_DONE:  state_nxt = RF_IDLE;
      default:  state_nxt = RF_IDLE;
    endcase
  end

  assign clr_busy = (state == RF_CLEAR);
  assign clr_done = (state == RF_DONE);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD combinational read ports, same-cycle
// write bypass, optional hardwired zero register and a sequential clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NREGS    = RF_NREGS,
  parameter int NREAD    = RF_NREAD,
  parameter bit ZERO_REG = RF_ZERO_REG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    wr_drop
);

  localparam int PTR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  rf_state_t          state;
  logic [PTR_W-1:0]   ptr;
  logic [DATA_W-1:0]  rf [NREGS];
  logic               wr_ok;

  regfile_clr_fsm #(.NREGS(NREGS), .PTR_W(PTR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .we       (we),
    .state    (state),
    .ptr      (ptr),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  // A write is legal only in IDLE, in range, and not aimed at a hardwired r0.
  assign wr_ok = we && (state == RF_IDLE) && (int'(wa) < NREGS) &&
                 !(ZERO_REG && (wa == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (state == RF_CLEAR) begin
      rf[ptr] <= '0;
    end else if (wr_ok) begin
      rf[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rdata;

    assign a = ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      rdata = '0;
      if ((int'(a) >= NREGS) || (ZERO_REG && (a == '0))) rdata = '0;
      else if (wr_ok && (a == wa))                          rdata = wd;
      else                                                  rdata = rf[a];
    end

    assign rd[g*DATA_W +: DATA_W] = rdata;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a driver pushes expected outputs from an
// array-based model, a negedge monitor pops and compares against the DUT.
module tb_regfile_mp;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NREGS    = 12;
  localparam int NREAD    = 3;
  localparam bit ZERO_REG = 1'b1;
  localparam int W        = NREAD*DATA_W + 3;

  logic                    clk;
  logic                    rst_n;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [DATA_W-1:0]       wd;
  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*DATA_W-1:0] rd;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;
  logic                    wr_drop;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS),
    .NREAD(NREAD), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rd       (rd),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // clr_pos: -1 idle, 0..NREGS-1 next register to clear, NREGS = done cycle
  int mem [NREGS];
  int clr_pos;
  bit drop_m;

  logic [W-1:0] exp_q [$];
  int n_cmp;
  int n_mis;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mem[i] = 0;
    clr_pos = -1;
    drop_m  = 1'b0;
  endtask

  function automatic logic [NREAD*ADDR_W-1:0] pk(input int a0, input int a1, input int a2);
    logic [NREAD*ADDR_W-1:0] v;
    v = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic w, input int a, input int d,
                      input logic [NREAD*ADDR_W-1:0] r, input logic c);
    logic [NREAD*DATA_W-1:0] dv;
    bit idle, legal, busy, done, drop_next;
    int ra_i, val;
    rst_n   = rn;
    we      = w;
    wa      = ADDR_W'(a);
    wd      = DATA_W'(d);
    ra      = r;
    clr_req = c;
    if (!rn) model_reset();
    idle  = (clr_pos < 0);
    legal = w && idle && (a < NREGS) && !(ZERO_REG && a == 0);
    for (int i = 0; i < NREAD; i++) begin
      ra_i = int'(r[i*ADDR_W +: ADDR_W]);
      if (ra_i >= NREGS || (ZERO_REG && ra_i == 0)) val = 0;
      else if (legal && ra_i == a)                  val = d;
      else                                          val = mem[ra_i];
      dv[i*DATA_W +: DATA_W] = DATA_W'(val);
    end
    busy = (clr_pos >= 0) && (clr_pos < NREGS);
    done = (clr_pos == NREGS);
    exp_q.push_back({busy, done, drop_m, dv});
    @(posedge clk);
    if (rn) begin
      drop_next = w && !idle;
      if (idle) begin
        if (legal) mem[a] = d & ((1 << DATA_W) - 1);
        if (c) clr_pos = 0;
      end else if (clr_pos < NREGS) begin
        mem[clr_pos] = 0;
        clr_pos++;
      end else begin
        clr_pos = -1;
      end
      drop_m = drop_next;
    end
    #1;
  endtask

  task automatic idle_read(input int a0, input int a1, input int a2);
    step(1'b1, 1'b0, 0, 0, pk(a0, a1, a2), 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {clr_busy, clr_done, wr_drop, rd};
      n_cmp++;
      if (act !== e) begin
        n_mis++;
        $display("FAIL outputs t=%0t {busy,done,drop,rd} actual=%h expected=%h",
                 $time, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; clr_req = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // reset state
    step(1'b0, 1'b0, 0, 0, pk(1, 3, 5), 1'b0);
    step(1'b0, 1'b0, 0, 0, pk(2, 4, 6), 1'b0);

    // bypass then stored value on two ports
    step(1'b1, 1'b1, 3, 'hA5, pk(3, 3, 1), 1'b0);
    idle_read(3, 3, 0);

    // hardwired zero and out-of-range
    step(1'b1, 1'b1, 0, 'hFF, pk(0, 0, 3), 1'b0);
    idle_read(0, 13, 15);
    step(1'b1, 1'b1, 13, 'h5A5A, pk(13, 0, 3), 1'b0);

    // fill and clear
    for (int i = 1; i < NREGS; i++) step(1'b1, 1'b1, i, i, pk(i, i - 1, NREGS - 1), 1'b0);
    for (int i = 0; i < NREGS; i += 3) idle_read(i, i + 1, i + 2);
    step(1'b1, 1'b0, 0, 0, pk(NREGS - 1, 5, 1), 1'b1);
    for (int k = 0; k < NREGS + 3; k++) begin
      if (k == 3) step(1'b1, 1'b1, 5, 'h77, pk(5, NREGS - 1, 4), 1'b0);
      else        idle_read(NREGS - 1, 5, k % NREGS);
    end
    for (int i = 0; i < NREGS; i += 3) idle_read(i, i + 1, i + 2);

    // reset mid-clear, then write after release
    for (int i = 1; i < NREGS; i++) step(1'b1, 1'b1, i, 'h100 + i, pk(i, 1, 2), 1'b0);
    step(1'b1, 1'b0, 0, 0, pk(9, 10, 11), 1'b1);
    for (int k = 0; k < 5; k++) idle_read(9, 10, 11);
    step(1'b0, 1'b0, 0, 0, pk(9, 10, 11), 1'b0);
    step(1'b0, 1'b0, 0, 0, pk(2, 5, 8), 1'b0);
    step(1'b1, 1'b1, 2, 'h12, pk(2, 9, 11), 1'b0);
    for (int k = 0; k < 3; k++) idle_read(2, 9, 11);

    // three ports with one concurrent write
    step(1'b1, 1'b1, 7, 'h1111, pk(7, 8, 9), 1'b0);
    step(1'b1, 1'b1, 8, 'h2222, pk(7, 8, 9), 1'b0);
    step(1'b1, 1'b1, 9, 'h3333, pk(7, 8, 9), 1'b0);
    step(1'b1, 1'b1, 8, 'hBEEF, pk(7, 8, 9), 1'b0);
    idle_read(7, 8, 9);

    // clr_req held high across DONE re-triggers
    step(1'b1, 1'b0, 0, 0, pk(1, 2, 3), 1'b1);
    for (int k = 0; k < 2*NREGS + 4; k++) step(1'b1, 1'b1, 4, k, pk(4, 1, 2), 1'b1);
    step(1'b1, 1'b0, 0, 0, pk(4, 1, 2), 1'b0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic rn, w, c;
      rn = ($urandom_range(0, 199) != 0);
      w  = rn && ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 39) == 0);
      step(rn, w, $urandom_range(0, 15), $urandom_range(0, 65535),
           pk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)), c);
    end
    step(1'b1, 1'b0, 0, 0, pk(1, 2, 3), 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
